// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared FSM state encoding and default sizes for updown_counter
package counter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_PAUSED = 2'b10
  } state_t;

  localparam int DEFAULT_WIDTH  = 4;
  localparam int DEFAULT_MODULO = 10;

endpackage

// File: rtl/updown_counter_if.sv
// rtl/updown_counter_if.sv - control/status bundle between a counter driver and updown_counter
interface updown_counter_if
  import counter_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
);

  logic             enable;
  logic             up;
  logic             start;
  logic             stop;
  logic             clear;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic [WIDTH-1:0] count;
  logic             carry;
  logic             running;

  modport master (
    output enable, up, start, stop, clear, load, load_value,
    input  count, carry, running
  );

  modport slave (
    input  enable, up, start, stop, clear, load, load_value,
    output count, carry, running
  );

endinterface

// File: rtl/counter_ctrl.sv
// rtl/counter_ctrl.sv - IDLE/RUN/PAUSED control FSM producing running and the count qualifier
module counter_ctrl
  import counter_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic stop,
  input  logic clear,
  input  logic enable,
  output logic running,
  output logic step
);

  state_t state;
  state_t state_next;

  // State register, asynchronously forced to IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state: clear dominates, stop beats start, the unused code falls back to IDLE.
  always_comb begin
    state_next = state;
    if (clear) begin
      state_next = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:   if (start && !stop) state_next = ST_RUN;
        ST_RUN:    if (stop)           state_next = ST_PAUSED;
        ST_PAUSED: if (start && !stop) state_next = ST_RUN;
        default:                       state_next = ST_IDLE;
      endcase
    end
  end

  // Outputs decode the registered state, so a start edge only counts from the next tick.
  always_comb begin
    running = (state == ST_RUN);
    step    = (state == ST_RUN) && enable;
  end

endmodule

// File: rtl/updown_counter.sv
// rtl/updown_counter.sv - modulo-N up/down counter with carry; COUNTER_SATURATE_EN selects saturate instead of wrap
module updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int MODULO = DEFAULT_MODULO
) (
  input  logic             clk,
  input  logic             reset,
  updown_counter_if.slave  bus
);

  localparam logic [WIDTH-1:0] MAX_VAL = WIDTH'(MODULO - 1);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH + 1)'(MODULO);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic             step;
  logic             running;
  logic [WIDTH-1:0] count_q;
  logic             carry_q;
  logic [WIDTH-1:0] step_value;
  logic             step_carry;
  logic [WIDTH-1:0] load_eff;

  counter_ctrl u_ctrl (
    .clk     (clk),
    .reset   (reset),
    .start   (bus.start),
    .stop    (bus.stop),
    .clear   (bus.clear),
    .enable  (bus.enable),
    .running (running),
    .step    (step)
  );

  // Value and carry the counter would take on a qualified tick in the sampled direction.
  always_comb begin
    step_value = count_q;
    step_carry = 1'b0;
    if (bus.up) begin
      if (count_q == MAX_VAL) begin
`ifdef COUNTER_SATURATE_EN
        step_value = MAX_VAL;
`else
        step_value = '0;
        step_carry = 1'b1;
`endif
      end else begin
        step_value = count_q + ONE;
`ifdef COUNTER_SATURATE_EN
        step_carry = (step_value == MAX_VAL);
`endif
      end
    end else begin
      if (count_q == '0) begin
`ifdef COUNTER_SATURATE_EN
        step_value = '0;
`else
        step_value = MAX_VAL;
        step_carry = 1'b1;
`endif
      end else begin
        step_value = count_q - ONE;
`ifdef COUNTER_SATURATE_EN
        step_carry = (step_value == '0);
`endif
      end
    end
  end

  // Out-of-range load values clamp to the top of the count range.
  always_comb begin
    load_eff = bus.load_value;
    if ({1'b0, bus.load_value} >= MOD_EXT) begin
      load_eff = MAX_VAL;
    end
  end

  // Count register with priority clear > load > step; carry lasts exactly one cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else if (bus.clear) begin
      count_q <= '0;
      carry_q <= 1'b0;
    end else if (bus.load) begin
      count_q <= load_eff;
      carry_q <= 1'b0;
    end else if (step) begin
      count_q <= step_value;
      carry_q <= step_carry;
    end else begin
      carry_q <= 1'b0;
    end
  end

  assign bus.count   = count_q;
  assign bus.carry   = carry_q;
  assign bus.running = running;

endmodule

// File: tb/tb_updown_counter.sv
// tb/tb_updown_counter.sv - directed vector bench for updown_counter (wrap build, or saturate with COUNTER_SATURATE_EN)
module tb_updown_counter;

  typedef struct {
    logic       start;
    logic       stop;
    logic       clear;
    logic       load;
    logic       enable;
    logic       up;
    logic [3:0] load_value;
    logic [3:0] exp_count;
    logic       exp_carry;
    logic       exp_running;
  } vec_t;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  vec_t vecs[$];

  updown_counter_if #(.WIDTH(4)) bus ();

  updown_counter #(.WIDTH(4), .MODULO(10)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic st, input logic sp, input logic cl, input logic ld,
                              input logic en, input logic u, input logic [3:0] lv,
                              input logic [3:0] c, input logic cy, input logic r);
    vec_t v;
    v.start = st; v.stop = sp; v.clear = cl; v.load = ld; v.enable = en; v.up = u;
    v.load_value = lv; v.exp_count = c; v.exp_carry = cy; v.exp_running = r;
    return v;
  endfunction

  task automatic check(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic check_outputs(input string name, input logic [3:0] c, input logic cy, input logic r);
    check({name, ".count"}, int'(bus.count), int'(c));
    check({name, ".carry"}, int'(bus.carry), int'(cy));
    check({name, ".running"}, int'(bus.running), int'(r));
  endtask

  task automatic drive(input logic st, input logic sp, input logic cl, input logic ld,
                       input logic en, input logic u, input logic [3:0] lv);
    bus.start = st; bus.stop = sp; bus.clear = cl; bus.load = ld;
    bus.enable = en; bus.up = u; bus.load_value = lv;
  endtask

  task automatic apply(input vec_t v, input string name);
    @(negedge clk);
    drive(v.start, v.stop, v.clear, v.load, v.enable, v.up, v.load_value);
    @(posedge clk);
    #1;
    check_outputs(name, v.exp_count, v.exp_carry, v.exp_running);
  endtask

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 1, 4'd0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    drive(0, 0, 0, 0, 0, 1, 4'd0);
    #3;
    check_outputs("reset", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

`ifndef COUNTER_SATURATE_EN
    // start, then 11 up ticks through the wrap
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    for (int i = 1; i <= 11; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 4'(i % 10), (i == 10), 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 0, 1, 0, 1));
    // down through zero
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 9, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 9, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8, 0, 1));
    // stop, ticks ignored, resume
    vecs.push_back(mk(0, 1, 0, 0, 0, 1, 0, 8, 0, 0));
    for (int i = 0; i < 3; i++)
      vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 8, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 1, 0, 8, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 9, 0, 1));
    // start+stop together: stop wins, paused stays paused
    vecs.push_back(mk(1, 1, 0, 0, 0, 1, 0, 9, 0, 0));
    vecs.push_back(mk(1, 1, 0, 0, 1, 1, 0, 9, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 9, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 1));
    // loads: clamp, coincident enable ignored
    vecs.push_back(mk(0, 0, 0, 1, 1, 1, 13, 9, 0, 1));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 4, 4, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 5, 0, 1));
    // clear overrides start, load and enable
    vecs.push_back(mk(1, 0, 1, 1, 1, 1, 3, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
    // load boundaries while idle
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 15, 9, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 10, 9, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 9, 1, 1));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 8, 0, 1));
    for (int i = 0; i < vecs.size(); i++)
      apply(vecs[i], $sformatf("v%0d", i));
`else
    begin
      int carries;
      carries = 0;
      apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1), "sat_start");
      for (int i = 1; i <= 15; i++) begin
        apply(mk(0, 0, 0, 0, 1, 1, 0, 4'((i > 9) ? 9 : i), (i == 9), 1), $sformatf("sat_up%0d", i));
        if (bus.carry) carries++;
      end
      check("sat_up_carry_total", carries, 1);
      for (int i = 1; i <= 11; i++)
        apply(mk(0, 0, 0, 0, 1, 0, 0, 4'((i > 9) ? 0 : 9 - i), (i == 9), 1), $sformatf("sat_dn%0d", i));
    end
`endif

    // async reset mid-cycle with a nonzero count
    do_reset();
    apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1), "rst_a_start");
    apply(mk(0, 0, 0, 1, 0, 1, 5, 5, 0, 1), "rst_a_load");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 6, 0, 1), "rst_a_tick");
    #2;
    reset = 1'b1;
    #1;
    check_outputs("rst_a_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;

    // async reset drops a pending carry
    apply(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 1), "rst_b_start");
`ifdef COUNTER_SATURATE_EN
    apply(mk(0, 0, 0, 1, 0, 1, 8, 8, 0, 1), "rst_b_load");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 9, 1, 1), "rst_b_tick");
`else
    apply(mk(0, 0, 0, 1, 0, 1, 9, 9, 0, 1), "rst_b_load");
    apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 1, 1), "rst_b_tick");
`endif
    #1;
    reset = 1'b1;
    #1;
    check_outputs("rst_b_async", 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    apply(mk(0, 0, 0, 0, 1, 1, 0, 0, 0, 0), "rst_b_idle_after");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
